// File: rtl/tca_pkg.sv
// Shared TCA protocol types: request/response structs and target state live here so
// that tca_if and the scheduler-side dispatcher agree on a single definition.
package tca_pkg;

   localparam int TCA_ADDR_W = 32;
   localparam int TCA_K_W    = 16;
   localparam int TCA_TAG_W  = 8;

   typedef struct packed {
      logic                  valid;
      logic [TCA_ADDR_W-1:0] base_addr;
      logic [TCA_K_W-1:0]    k;
   } tca_req_t;

   typedef struct packed {
      logic valid;
      logic complete;
      logic error;
   } tca_res_t;

   typedef enum logic [1:0] {
      TCA_IDLE,
      TCA_BUSY,
      TCA_DONE,
      TCA_FAULT
   } tca_state_t;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      RETIRE
   } tca_disp_state_t;

   typedef struct packed {
      logic [TCA_TAG_W-1:0] tag;
      tca_req_t             payload;
   } tca_job_t;

   localparam int TCA_REQ_W = $bits(tca_req_t);
   localparam int TCA_RES_W = $bits(tca_res_t);

endpackage

// File: rtl/tca_job_fifo.sv
// Synchronous FIFO of arbitrary element type; pointers wrap modulo DEPTH (power of 2).
// Overflowing pushes and underflowing pops are ignored.
module tca_job_fifo #(
   parameter int  DEPTH = 4,
   parameter type T     = logic [7:0]
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  T                       wdata,
   input  logic                   pop,
   output T                       rdata,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   T              mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] cnt;
   logic          do_push;
   logic          do_pop;

   assign full    = (cnt == CW'(DEPTH));
   assign empty   = (cnt == '0);
   assign count   = cnt;
   assign rdata   = mem[rd_ptr];
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
         cnt <= cnt + CW'(do_push) - CW'(do_pop);
      end
   end

endmodule

// File: rtl/tca_dispatch.sv
// Scheduler-side TCA initiator: queues tagged jobs, issues one at a time, retries on
// error, abandons hung jobs after a silent window, and reports one completion per job.
module tca_dispatch
   import tca_pkg::*;
#(
   parameter int QUEUE_DEPTH    = 4,
   parameter int TIMEOUT_CYCLES = 4096,
   parameter int MAX_RETRY      = 2,
   parameter int TAG_W          = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         job_valid,
   output logic                         job_ready,
   input  logic [TCA_REQ_W-1:0]         job_req,
   output logic [TCA_REQ_W-1:0]         tca_req,
   input  logic [TCA_RES_W-1:0]         tca_res,
   output logic                         done_valid,
   output logic [TAG_W-1:0]             done_tag,
   output logic                         done_error,
   output logic                         done_timeout,
   output logic                         busy,
   output logic [$clog2(QUEUE_DEPTH):0] q_count
);

   localparam int CW = $clog2(QUEUE_DEPTH) + 1;
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int RW = $clog2(MAX_RETRY + 2);

   tca_disp_state_t state, state_n;
   tca_job_t        head, wr_job, job_q, job_n;
   tca_req_t        req_q, req_n;
   tca_res_t        res;
   logic [CW-1:0]   count, count_n;
   logic [RW-1:0]   retry_cnt, retry_n;
   logic [TW-1:0]   tmo_cnt, tmo_n;
   logic [TAG_W-1:0] tag_cnt;
   logic            push, pop, full, empty;
   logic            done_n, err_n, to_n;
   logic            ready_q, busy_q, done_valid_q, done_error_q, done_timeout_q;
   logic [TAG_W-1:0] done_tag_q;

   assign res     = tca_res;
   assign push    = job_valid && ready_q && !full;
   assign pop     = (state == IDLE) && !empty;
   assign count_n = count + CW'(push) - CW'(pop);

   always_comb begin
      wr_job.tag           = TCA_TAG_W'(tag_cnt);
      wr_job.payload       = job_req;
      wr_job.payload.valid = 1'b0;
   end

   tca_job_fifo #(
      .DEPTH (QUEUE_DEPTH),
      .T     (tca_job_t)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .wdata (wr_job),
      .pop   (pop),
      .rdata (head),
      .full  (full),
      .empty (empty),
      .count (count)
   );

   // A response in the firing cycle wins over the timeout; error wins over complete.
   always_comb begin
      state_n = state;
      job_n   = job_q;
      retry_n = retry_cnt;
      tmo_n   = tmo_cnt;
      done_n  = 1'b0;
      err_n   = 1'b0;
      to_n    = 1'b0;
      case (state)
         IDLE: begin
            if (!empty) begin
               job_n   = head;
               retry_n = '0;
               state_n = ISSUE;
            end
         end
         ISSUE: begin
            tmo_n   = '0;
            state_n = WAIT;
         end
         WAIT: begin
            if (res.valid) begin
               if (res.error) begin
                  if (retry_cnt < RW'(MAX_RETRY)) begin
                     retry_n = retry_cnt + RW'(1);
                     state_n = ISSUE;
                  end else begin
                     state_n = RETIRE;
                     done_n  = 1'b1;
                     err_n   = 1'b1;
                  end
               end else if (res.complete) begin
                  state_n = RETIRE;
                  done_n  = 1'b1;
               end else begin
                  tmo_n = '0;
               end
            end else if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
               state_n = RETIRE;
               done_n  = 1'b1;
               err_n   = 1'b1;
               to_n    = 1'b1;
            end else begin
               tmo_n = tmo_cnt + TW'(1);
            end
         end
         RETIRE: state_n = IDLE;
         default: state_n = IDLE;
      endcase
      req_n       = job_n.payload;
      req_n.valid = (state_n == ISSUE);
   end

   // Outputs are loaded from next-state values so they line up with the state they describe.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= IDLE;
         job_q          <= '0;
         retry_cnt      <= '0;
         tmo_cnt        <= '0;
         tag_cnt        <= '0;
         req_q          <= '0;
         ready_q        <= 1'b0;
         busy_q         <= 1'b0;
         done_valid_q   <= 1'b0;
         done_tag_q     <= '0;
         done_error_q   <= 1'b0;
         done_timeout_q <= 1'b0;
      end else begin
         state          <= state_n;
         job_q          <= job_n;
         retry_cnt      <= retry_n;
         tmo_cnt        <= tmo_n;
         if (push) tag_cnt <= tag_cnt + TAG_W'(1);
         req_q          <= req_n;
         ready_q        <= (count_n != CW'(QUEUE_DEPTH));
         busy_q         <= (state_n != IDLE) || (count_n != '0);
         done_valid_q   <= done_n;
         if (done_n) done_tag_q <= TAG_W'(job_q.tag);
         done_error_q   <= err_n;
         done_timeout_q <= to_n;
      end
   end

   assign job_ready    = ready_q;
   assign tca_req      = req_q;
   assign done_valid   = done_valid_q;
   assign done_tag     = done_tag_q;
   assign done_error   = done_error_q;
   assign done_timeout = done_timeout_q;
   assign busy         = busy_q;
   assign q_count      = count;

endmodule

// File: doc/tca_dispatch.md
Name: tca_dispatch

Overview:
- Scheduler-side initiator for the TCA request/response protocol.
- Queues tile jobs from the scheduler core and issues them to the TCA one at a time as `tca_req_t` pulses.
- Tracks each job's `tca_res_t` outcome, retries jobs that report an error, and times out jobs that hang.
- Reports a tagged completion per job back to the scheduler core.

Parameters:
- QUEUE_DEPTH, 4, job FIFO entries (power of 2, ≥2).
- TIMEOUT_CYCLES, 4096, maximum cycles in WAIT without any `tca_res.valid` before a job is abandoned.
- MAX_RETRY, 2, re-issues allowed after an error response.
- TAG_W, 8, width of the job sequence tag.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- job_valid  in  1  scheduler core offers a job.
- job_ready  out  1  FIFO can accept the job; equals !full.
- job_req  in  `$bits(tca_req_t)`  job payload; its `valid` field is ignored.
- tca_req  out  `$bits(tca_req_t)`  request to the TCA (`scheduler_tca_req`).
- tca_res  in  `$bits(tca_res_t)`  response from the TCA (`tca_scheduler_res`).
- done_valid  out  1  one-cycle job retirement pulse.
- done_tag  out  TAG_W  tag of the retired job.
- done_error  out  1  retired job failed (error after retries, or timeout).
- done_timeout  out  1  retired job failed by timeout.
- busy  out  1  FSM not IDLE, or FIFO non-empty.
- q_count  out  `$clog2(QUEUE_DEPTH)+1`  FIFO occupancy.

Behaviour:
- Reset (asynchronous, active-high): all outputs are 0, including the whole `tca_req` struct. FIFO is emptied, tag counter = 0, retry_cnt = 0, timeout counter = 0, FSM = IDLE. An in-flight job is abandoned silently and produces no done pulse.
- Push: a job is accepted on the edge where `job_valid && job_ready`. It is assigned tag = tag counter, which then increments and wraps modulo 2^TAG_W. `job_ready` does not depend on a same-cycle pop, so a full FIFO refuses a push even in a cycle where it pops.
- All outputs are registered.
- FSM states:
  - IDLE: if the FIFO is non-empty, latch the head entry, pop it, clear retry_cnt, and go to ISSUE.
  - ISSUE: drive `tca_req` = latched payload with `valid` = 1 for exactly one cycle. Clear the timeout counter and go to WAIT.
  - WAIT: `tca_req.valid` = 0 while the payload is held. Priority on `tca_res.valid`:
    - `error` = 1 (regardless of `complete`): if retry_cnt < MAX_RETRY, increment retry_cnt and go to ISSUE. Otherwise go to RETIRE with error.
    - `complete` = 1, `error` = 0: go to RETIRE with success.
    - `complete` = 0, `error` = 0: heartbeat. Clear the timeout counter and stay in WAIT.
    - No `valid` and counter == TIMEOUT_CYCLES-1: go to RETIRE with error and timeout. No retry is attempted after a timeout.
    - No `valid` otherwise: increment the counter.
    - A `tca_res.valid` arriving in the same cycle the timeout would fire takes precedence over the timeout.
  - RETIRE: `done_valid` = 1 for one cycle with the tag and flags, then go to IDLE.
- `tca_res.valid` outside WAIT is ignored.
- Latency:
  - A push in cycle t into an empty, idle block gives `tca_req.valid` in cycle t+2.
  - A response in cycle w gives `done_valid` in cycle w+1.
  - The next issue occurs no earlier than w+3.
- Only one job is outstanding at a time. Jobs retire in FIFO order.
- FIFO pointers wrap modulo QUEUE_DEPTH. `q_count` ranges from 0 to QUEUE_DEPTH.

Decomposition:
- Move `tca_req_t`, `tca_res_t` and `tca_state_t` out of `tca_if` into `tca_pkg`, so that `tca_if` and this block share them.
- Add to `tca_pkg`: `tca_disp_state_t` {IDLE, ISSUE, WAIT, RETIRE} and a `tca_job_t` struct {tag, payload}.
- Sub-module `tca_job_fifo`: synchronous FIFO parameterised by depth and type, with full, empty and count outputs. The FSM and counters stay in the top module.

Test Plan:
- Reset, then one job (base_addr = 0x40, K = 16) pushed at cycle 0 -> `tca_req.valid` at cycle 2 with base_addr 0x40. `tca_res` {1,1,0} at cycle 10 -> `done_valid` at cycle 11 with tag 0 and `done_error` = 0.
- Push 5 jobs back-to-back with QUEUE_DEPTH = 4 while the first is in WAIT -> `job_ready` is 0 only when `q_count` = 4. All 5 retire in order with tags 0..4.
- Respond with error on every issue of a job -> exactly 3 `tca_req.valid` pulses (1 + MAX_RETRY), then `done_error` = 1 and `done_timeout` = 0. Error on the first issue and complete on the second -> success.
- No response with TIMEOUT_CYCLES = 16 -> `done_valid` 17 cycles after the issue, with `done_error` = 1 and `done_timeout` = 1. A heartbeat at cycle 10 postpones the retire to cycle 10+17.
- Assert rst while in WAIT with 2 jobs queued -> all outputs are 0 immediately, `q_count` = 0, no `done_valid`. The next pushed job gets tag 0.
- Push 260 jobs -> `done_tag` wraps from 255 to 0.
